// File: rtl/mem_arbiter_if.sv
// Bundles the requester-side and memory-side handshakes of mem_arbiter.
// The master modport is the arbiter's view; slave is the surrounding system's view.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) ();
    logic [NUM_REQ-1:0]        req_ce_i;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [DATA_W-1:0]         req_data_o;
    logic                      mem_ce_o;
    logic                      mem_we_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_data_o;
    logic [DATA_W-1:0]         mem_data_i;
    logic                      mem_ready_i;
    logic [2:0]                grant_o;
    logic                      busy_o;

    modport master (
        input  req_ce_i, req_we_i, req_addr_i, req_data_i, mem_data_i, mem_ready_i,
        output req_ready_o, req_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_data_o,
               grant_o, busy_o
    );

    modport slave (
        output req_ce_i, req_we_i, req_addr_i, req_data_i, mem_data_i, mem_ready_i,
        input  req_ready_o, req_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_data_o,
               grant_o, busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters.
// Accesses are fully serialised: IDLE -> BUSY (wait mem_ready_i) -> RELEASE -> IDLE.
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.master    bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDX_W-1:0];
    endfunction

    // Scan offsets from the far end so the requester closest to rr_ptr wins.
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_ce_i[wrap_add(rr_ptr, i)]) begin
                sel_valid = 1'b1;
                sel_idx   = wrap_add(rr_ptr, i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            bus.req_ready_o <= '0;
            bus.req_data_o  <= '0;
            bus.mem_ce_o    <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_data_o  <= '0;
            bus.grant_o     <= '0;
            bus.busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        bus.mem_ce_o   <= 1'b1;
                        bus.mem_we_o   <= bus.req_we_i[sel_idx];
                        bus.mem_addr_o <= bus.req_addr_i[sel_idx*ADDR_W +: ADDR_W];
                        bus.mem_data_o <= bus.req_data_i[sel_idx*DATA_W +: DATA_W];
                        bus.grant_o    <= 3'(sel_idx);
                        bus.busy_o     <= 1'b1;
                        rr_ptr         <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready_i) begin
                        bus.mem_ce_o    <= 1'b0;
                        bus.req_ready_o <= NUM_REQ'(1) << bus.grant_o;
                        bus.req_data_o  <= bus.mem_data_i;
                        state           <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Granted requester still shows ce here; arbitrating now would re-serve it.
                    bus.req_ready_o <= '0;
                    bus.busy_o      <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
